rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Controls the single write port of the 32x32 register file.
- Two writeback sources share that port: the in-order pipeline WB stage, and a long-latency unit (mul/div/load-miss) that uses a valid/ready handshake.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations and drives the decode RAW/WAW stall.
- Bounds long-latency starvation by asking the pipeline for a WB bubble.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles ll_valid may be refused before hold_pipe asserts (1..15).
- CNT_W, 4: starve counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- wb_wr  in  1  pipeline writeback enable
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- ll_issue  in  1  long-latency op issued this cycle
- ll_issue_addr  in  5  destination of the issued long-latency op
- ll_valid  in  1  long-latency result available
- ll_addr  in  5  long-latency result destination
- ll_data  in  32  long-latency result data
- ll_ready  out  1  long-latency result accepted this cycle
- rs_addr  in  5  decode source register 1
- rt_addr  in  5  decode source register 2
- rd_addr  in  5  decode destination register (WAW check)
- raw_stall  out  1  decode must stall
- hold_pipe  out  1  pipeline must present wb_wr=0 this cycle
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- rf_wr  out  1  register file write enable
- wb_drop_err  out  1  sticky: a pipeline write was dropped

Behaviour:
- Reset (asynchronous, rst_n=0):
  - busy[31:1]=0, starve_cnt=0, wb_drop_err=0.
  - Outputs settle to ll_ready=1, raw_stall=0, hold_pipe=0, rf_wr=0, rf_waddr=0, rf_wdata=0.
- Write-port select is combinational, zero latency, so the register file's same-cycle bypass still works:
  - wb_eff = wb_wr & (wb_addr!=0) & ~hold_pipe.
  - ll_ready = hold_pipe | ~wb_eff.
  - ll_fire = ll_valid & ll_ready.
  - If wb_eff: port gets {wb_addr, wb_data}. Else if ll_fire: port gets {ll_addr, ll_data}. Else rf_waddr=0, rf_wdata=0.
  - rf_wr = wb_eff | (ll_fire & ll_addr!=0).
  - A write to $0 never asserts rf_wr. A long-latency result to $0 still handshakes.
- Priority: the pipeline wins unless hold_pipe=1.
- wb_drop_err sets when wb_wr & wb_addr!=0 & hold_pipe; it clears only on reset.
- starve_cnt (registered):
  - Cleared when ll_fire or ~ll_valid.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - hold_pipe = (starve_cnt==STARVE_LIMIT), decoded from the register.
  - hold_pipe is therefore high for exactly one cycle: the next cycle's forced ll_fire clears the counter.
- Scoreboard busy[r], r=1..31, updated at the clock edge:
  - Set if ll_issue & ll_issue_addr==r.
  - Cleared if ll_fire & ll_addr==r.
  - Set wins when both hit the same r in the same cycle.
  - busy[0] is constant 0.
- raw_stall = busy[rs_addr] | busy[rt_addr] | busy[rd_addr], using current register state.
  - A same-cycle ll_fire does not unstall; the stall drops the next cycle, when the register file already holds the data.
- ll_valid must hold with stable ll_addr/ll_data until ll_ready; the block does not check this.
- Reset asserted mid-operation clears all busy bits and the counter immediately. A pending ll_valid is accepted normally after reset release.

Test Plan:
- Reset: after rst_n release, inputs idle -> rf_wr=0, ll_ready=1, raw_stall=0, hold_pipe=0, wb_drop_err=0.
- Conflict: wb_wr=1 wb_addr=5 wb_data=0x11 together with ll_valid=1 ll_addr=6 ll_data=0x22 -> rf_wr=1 rf_waddr=5 rf_wdata=0x11 ll_ready=0. Next cycle wb_wr=0 -> rf_waddr=6 rf_wdata=0x22, ll_ready=1.
- Scoreboard: ll_issue addr=8 -> next cycle rs_addr=8 gives raw_stall=1. ll_fire addr=8 -> raw_stall=0 the following cycle. rd_addr=8 while busy -> raw_stall=1.
- Starvation (STARVE_LIMIT=4): ll_valid=1 ll_addr=3 with wb_wr=1 to addr 7 every cycle -> hold_pipe=1 on cycle 5, ll_ready=1, rf_waddr=3. Cycle 6: hold_pipe=0. If wb_wr=1 during cycle 5 -> wb_drop_err=1.
- $0 handling: wb_wr=1 wb_addr=0 with ll_valid addr=0 -> rf_wr=0, ll_ready=1. ll_issue addr=0 -> raw_stall stays 0.
- Same-edge set/clear: ll_fire addr=9 with ll_issue addr=9 in the same cycle -> busy[9] remains 1. Async reset mid-stall -> raw_stall=0 immediately.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Register-file write-port bundle: pipeline WB, long-latency handshake,
// decode hazard query and the register-file write port.
interface rf_wb_arbiter_if;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ll_issue;
    logic [4:0]  ll_issue_addr;
    logic        ll_valid;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        raw_stall;
    logic        hold_pipe;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wr;
    logic        wb_drop_err;

    modport master (
        output wb_wr, wb_addr, wb_data,
        output ll_issue, ll_issue_addr,
        output ll_valid, ll_addr, ll_data,
        output rs_addr, rt_addr, rd_addr,
        input  ll_ready, raw_stall, hold_pipe,
        input  rf_waddr, rf_wdata, rf_wr, wb_drop_err
    );

    modport slave (
        input  wb_wr, wb_addr, wb_data,
        input  ll_issue, ll_issue_addr,
        input  ll_valid, ll_addr, ll_data,
        input  rs_addr, rt_addr, rd_addr,
        output ll_ready, raw_stall, hold_pipe,
        output rf_waddr, rf_wdata, rf_wr, wb_drop_err
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs long-latency results,
// busy scoreboard for decode stalls, bounded long-latency starvation.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input logic            clk,
    input logic            rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             wb_drop_err_q, wb_drop_err_d;

    logic hold;
    logic wb_eff;
    logic ll_fire;

    assign hold    = (starve_cnt_q == LIMIT);
    assign wb_eff  = bus.wb_wr & (bus.wb_addr != 5'd0) & ~hold;
    assign ll_fire = bus.ll_valid & (hold | ~wb_eff);

    always_comb begin
        bus.hold_pipe   = hold;
        bus.ll_ready    = hold | ~wb_eff;
        bus.rf_wr       = wb_eff | (ll_fire & (bus.ll_addr != 5'd0));
        bus.wb_drop_err = wb_drop_err_q;
        bus.raw_stall   = busy_q[bus.rs_addr] | busy_q[bus.rt_addr]
                        | busy_q[bus.rd_addr];
        bus.rf_waddr    = 5'd0;
        bus.rf_wdata    = 32'd0;
        if (wb_eff) begin
            bus.rf_waddr = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
        end else if (ll_fire) begin
            bus.rf_waddr = bus.ll_addr;
            bus.rf_wdata = bus.ll_data;
        end
    end

    // Issue is applied after retire so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (ll_fire)
            busy_d[bus.ll_addr] = 1'b0;
        if (bus.ll_issue)
            busy_d[bus.ll_issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ll_fire | ~bus.ll_valid)
            starve_cnt_d = '0;
        else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_comb begin
        wb_drop_err_d = wb_drop_err_q;
        if (bus.wb_wr & (bus.wb_addr != 5'd0) & hold)
            wb_drop_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            starve_cnt_q  <= '0;
            wb_drop_err_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            starve_cnt_q  <= starve_cnt_d;
            wb_drop_err_q <= wb_drop_err_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, scoreboard,
// starvation bubble, $0 handling and async reset.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_wr = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ll_issue = 0; bus.ll_issue_addr = 0;
        bus.ll_valid = 0; bus.ll_addr = 0; bus.ll_data = 0;
        bus.rs_addr = 0; bus.rt_addr = 0; bus.rd_addr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        n_checks++;
        if (bus.rf_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rf_wr got %b exp 0", bus.rf_wr);
        end
        n_checks++;
        if (bus.ll_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ll_ready got %b exp 1", bus.ll_ready);
        end
        n_checks++;
        if ({bus.raw_stall, bus.hold_pipe, bus.wb_drop_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 000",
                     {bus.raw_stall, bus.hold_pipe, bus.wb_drop_err});
        end
        n_checks++;
        if ({bus.rf_waddr, bus.rf_wdata} !== 37'd0) begin
            n_errors++;
            $display("FAIL reset_port got %h/%h exp 0/0",
                     bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_conflict();
        bus.wb_wr = 1; bus.wb_addr = 5; bus.wb_data = 32'h11;
        bus.ll_valid = 1; bus.ll_addr = 6; bus.ll_data = 32'h22;
        #1;
        n_checks++;
        if ({bus.rf_wr, bus.rf_waddr, bus.rf_wdata, bus.ll_ready}
            !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
            n_errors++;
            $display("FAIL conflict_wb got wr=%b a=%0d d=%h rdy=%b exp 1/5/11/0",
                     bus.rf_wr, bus.rf_waddr, bus.rf_wdata, bus.ll_ready);
        end
        tick();
        bus.wb_wr = 0;
        #1;
        n_checks++;
        if ({bus.rf_wr, bus.rf_waddr, bus.rf_wdata, bus.ll_ready}
            !== {1'b1, 5'd6, 32'h22, 1'b1}) begin
            n_errors++;
            $display("FAIL conflict_ll got wr=%b a=%0d d=%h rdy=%b exp 1/6/22/1",
                     bus.rf_wr, bus.rf_waddr, bus.rf_wdata, bus.ll_ready);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        bus.ll_issue = 1; bus.ll_issue_addr = 8;
        bus.rs_addr = 8;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_before_issue got %b exp 0", bus.raw_stall);
        end
        tick();
        bus.ll_issue = 0;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sb_rs_busy got %b exp 1", bus.raw_stall);
        end
        bus.rs_addr = 0; bus.rd_addr = 8;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sb_rd_busy got %b exp 1", bus.raw_stall);
        end
        bus.ll_valid = 1; bus.ll_addr = 8; bus.ll_data = 32'h88;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sb_same_cycle got %b exp 1", bus.raw_stall);
        end
        tick();
        bus.ll_valid = 0;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_cleared got %b exp 0", bus.raw_stall);
        end
        idle();
        tick();
    endtask

    task automatic test_starvation();
        bus.wb_wr = 1; bus.wb_addr = 7; bus.wb_data = 32'h77;
        bus.ll_valid = 1; bus.ll_addr = 3; bus.ll_data = 32'h33;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++;
            if ({bus.hold_pipe, bus.ll_ready, bus.rf_waddr} !== {2'b00, 5'd7}) begin
                n_errors++;
                $display("FAIL starve_cycle%0d got hold=%b rdy=%b a=%0d exp 0/0/7",
                         c, bus.hold_pipe, bus.ll_ready, bus.rf_waddr);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({bus.hold_pipe, bus.ll_ready, bus.rf_wr, bus.rf_waddr, bus.rf_wdata}
            !== {3'b111, 5'd3, 32'h33}) begin
            n_errors++;
            $display("FAIL starve_hold got hold=%b rdy=%b wr=%b a=%0d d=%h exp 1/1/1/3/33",
                     bus.hold_pipe, bus.ll_ready, bus.rf_wr,
                     bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.wb_drop_err !== 1'b0) begin
            n_errors++;
            $display("FAIL starve_drop_early got %b exp 0", bus.wb_drop_err);
        end
        tick();
        bus.ll_valid = 0;
        #1;
        n_checks++;
        if ({bus.hold_pipe, bus.rf_waddr, bus.wb_drop_err} !== {1'b0, 5'd7, 1'b1}) begin
            n_errors++;
            $display("FAIL starve_after got hold=%b a=%0d drop=%b exp 0/7/1",
                     bus.hold_pipe, bus.rf_waddr, bus.wb_drop_err);
        end
        idle();
        tick();
    endtask

    task automatic test_zero();
        bus.wb_wr = 1; bus.wb_addr = 0; bus.wb_data = 32'hAA;
        bus.ll_valid = 1; bus.ll_addr = 0; bus.ll_data = 32'hBB;
        #1;
        n_checks++;
        if ({bus.rf_wr, bus.ll_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL zero_port got wr=%b rdy=%b exp 0/1",
                     bus.rf_wr, bus.ll_ready);
        end
        tick();
        idle();
        bus.ll_issue = 1; bus.ll_issue_addr = 0;
        tick();
        bus.ll_issue = 0;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_issue got %b exp 0", bus.raw_stall);
        end
        tick();
    endtask

    task automatic test_same_edge();
        bus.ll_issue = 1; bus.ll_issue_addr = 9;
        tick();
        bus.ll_valid = 1; bus.ll_addr = 9; bus.ll_data = 32'h99;
        #1;
        n_checks++;
        if ({bus.rf_wr, bus.rf_waddr} !== {1'b1, 5'd9}) begin
            n_errors++;
            $display("FAIL same_edge_fire got wr=%b a=%0d exp 1/9",
                     bus.rf_wr, bus.rf_waddr);
        end
        tick();
        idle();
        bus.rs_addr = 9;
        #1;
        n_checks++;
        if (bus.raw_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL same_edge_busy got %b exp 1", bus.raw_stall);
        end
        #2;
        bus.ll_valid = 1; bus.ll_addr = 10; bus.ll_data = 32'hA0;
        rst_n = 0;
        #1;
        n_checks++;
        if ({bus.raw_stall, bus.wb_drop_err} !== 2'b00) begin
            n_errors++;
            $display("FAIL async_reset got stall=%b drop=%b exp 0/0",
                     bus.raw_stall, bus.wb_drop_err);
        end
        tick();
        rst_n = 1;
        #1;
        n_checks++;
        if ({bus.ll_ready, bus.rf_wr, bus.rf_waddr, bus.rf_wdata}
            !== {2'b11, 5'd10, 32'hA0}) begin
            n_errors++;
            $display("FAIL post_reset_accept got rdy=%b wr=%b a=%0d d=%h exp 1/1/10/a0",
                     bus.ll_ready, bus.rf_wr, bus.rf_waddr, bus.rf_wdata);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_scoreboard();
        test_starvation();
        test_zero();
        test_same_edge();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
